// File: rtl/rr_mux_arbiter_4_if.sv
// Valid/ready bundle between four producers, the arbiter and one consumer.
interface rr_mux_arbiter_4_if #(
  parameter int unsigned W = 4
);
  logic [3:0]   in_valid;
  logic [W-1:0] in_data0;
  logic [W-1:0] in_data1;
  logic [W-1:0] in_data2;
  logic [W-1:0] in_data3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         out_ready;
  logic [1:0]   sel;

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_src, sel
  );

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_src, sel
  );
endinterface

// File: rtl/rr_mux_arbiter_4.sv
// Four-way round-robin arbiter driving a 4:1 mux into a single registered output stage.
// Define RR_MUX_ARBITER_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module rr_mux_arbiter_4 #(
  parameter int unsigned W = 4
) (
  input logic               clk,
  input logic               rst,
  rr_mux_arbiter_4_if.slave bus
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic [1:0]   r_out_src;
`ifndef RR_MUX_ARBITER_FIXED_PRIO_EN
  logic [1:0]   r_last;
`endif

  logic         w_can_load;
  logic         w_found;
  logic         w_grant;
  logic [1:0]   w_idx;
  logic [1:0]   w_sel;
  logic [W-1:0] w_mux_data;

  assign w_can_load = !r_out_valid || bus.out_ready;

  // Winner search: first valid requester starting one past the last grant.
  always_comb begin
    w_sel   = 2'd0;
    w_found = 1'b0;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
`ifdef RR_MUX_ARBITER_FIXED_PRIO_EN
      w_idx = 2'(k);
`else
      w_idx = r_last + 2'(k + 1);
`endif
      if (!w_found && bus.in_valid[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_grant = w_can_load && w_found && !rst;

  always_comb begin
    w_mux_data = '0;
    case (w_sel)
      2'd0:    w_mux_data = bus.in_data0;
      2'd1:    w_mux_data = bus.in_data1;
      2'd2:    w_mux_data = bus.in_data2;
      default: w_mux_data = bus.in_data3;
    endcase
  end

  // Output stage: a load overrides a simultaneous drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 2'd0;
`ifndef RR_MUX_ARBITER_FIXED_PRIO_EN
      r_last      <= 2'd3;
`endif
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_src   <= w_sel;
`ifndef RR_MUX_ARBITER_FIXED_PRIO_EN
      r_last      <= w_sel;
`endif
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_grant ? 4'(4'b0001 << w_sel) : 4'b0000;
  assign bus.sel       = w_sel;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;

endmodule
